// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: baud select codes (also
// decoded by the baud generator) and the scheduler state encoding.
package uart_pkg;

  localparam logic [1:0] BAUD24  = 2'b00;
  localparam logic [1:0] BAUD48  = 2'b01;
  localparam logic [1:0] BAUD96  = 2'b10;
  localparam logic [1:0] BAUD192 = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The slot after last_grant has the
// highest priority, wrapping modulo N. Also intended for the Rx buffer drain.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic [IW-1:0] slot;

  // Scan from the farthest slot to the nearest so the nearest hit is written last and wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    slot      = '0;
    any_req   = |req;
    for (int off = N; off >= 1; off--) begin
      slot = IW'((int'(last_grant) + off) % N);
      if (req[slot]) begin
        grant       = '0;
        grant[slot] = 1'b1;
        grant_idx   = slot;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte requesters in round-robin
// order and owns the baud select, changing it only while no frame is active.
//
// Requester handshake: a byte moves when req_valid[i] and req_ready[i] are both
// high at a rising clock edge. req_ready is one-hot, combinational, and only
// asserted in IDLE when no baud change is waiting; req_valid may be withdrawn
// at any time without a transfer, and req_data is sampled only on that edge.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int          NUM_REQ       = 4,
  parameter logic [1:0]  BAUD_DEFAULT  = BAUD192,
  parameter int          START_TIMEOUT = 16,
  localparam int         IDW           = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 cfg_update,
  input  logic [1:0]           cfg_baud,
  output logic [1:0]           baud_rate,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 sched_busy,
  output logic                 frame_done,
  output logic                 err_timeout,
  output sched_state_t         state_dbg
);

  localparam int CW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

  sched_state_t   state_q, state_d;
  logic [1:0]     baud_q, pend_baud_q;
  logic           pend_q;
  logic [IDW-1:0] last_grant_q, grant_id_q;
  logic [7:0]     tx_data_q;
  logic           frame_done_q, err_q;
  logic [CW-1:0]  cnt_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_idx;
  logic               arb_any;
  logic [7:0]         sel_byte;
  logic               cfg_apply, take, busy_timeout;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any_req    (arb_any)
  );

  // A pending (or same-cycle) baud change in IDLE wins over a new grant
  assign cfg_apply = (state_q == IDLE) && (pend_q || cfg_update);
  assign take      = (state_q == IDLE) && !cfg_apply && arb_any;

  // The counter stops one short of START_TIMEOUT-1; the next increment would reach it
  assign busy_timeout = (state_q == WAIT_BUSY) && !tx_busy &&
                        (cnt_q == CW'(START_TIMEOUT - 2));

  // Pick the granted requester's byte
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDW'(i)) sel_byte = req_data[8*i +: 8];
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and combinational outputs
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    tx_start   = 1'b0;
    sched_busy = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (take) begin
          req_ready = arb_grant;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start = 1'b1;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy)           state_d = WAIT_DONE;
        else if (busy_timeout) state_d = IDLE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Baud configuration: capture at any time, apply only in IDLE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_q      <= BAUD_DEFAULT;
      pend_baud_q <= BAUD_DEFAULT;
      pend_q      <= 1'b0;
    end else if (cfg_apply) begin
      baud_q <= cfg_update ? cfg_baud : pend_baud_q;
      pend_q <= 1'b0;
    end else if (cfg_update) begin
      pend_baud_q <= cfg_baud;
      pend_q      <= 1'b1;
    end
  end

  // Grant bookkeeping, start-timeout counter and completion pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= IDW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      tx_data_q    <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (take) begin
        tx_data_q    <= sel_byte;
        grant_id_q   <= arb_idx;
        last_grant_q <= arb_idx;
      end
      if (state_q == LAUNCH) cnt_q <= '0;
      else if ((state_q == WAIT_BUSY) && !tx_busy && !busy_timeout) cnt_q <= cnt_q + 1'b1;
      frame_done_q <= (state_q == WAIT_DONE) && !tx_busy;
      err_q        <= busy_timeout;
    end
  end

  assign baud_rate   = baud_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign frame_done  = frame_done_q;
  assign err_timeout = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: transmitter model, event-timed reference model
// with a per-cycle compare process, directed scenarios and random traffic.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ       = 4;
  localparam int START_TIMEOUT = 16;
  localparam int IDW           = 2;

  // ---------------- clock / reset / signals ----------------
  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 cfg_update = 1'b0;
  logic [1:0]           cfg_baud = 2'b00;
  logic [1:0]           baud_rate;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy = 1'b0;
  logic [IDW-1:0]       grant_id;
  logic                 sched_busy, frame_done, err_timeout;
  logic [1:0]           state_dbg;

  always #5 clock = ~clock;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .BAUD_DEFAULT(2'b11), .START_TIMEOUT(START_TIMEOUT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cfg_update  (cfg_update),
    .cfg_baud    (cfg_baud),
    .baud_rate   (baud_rate),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .sched_busy  (sched_busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout),
    .state_dbg   (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- transmitter model ----------------
  // Busy rises the cycle after tx_start and stays high frame_len cycles.
  int   frame_len = 4;
  logic tx_ignore = 1'b0;
  int   tx_left = 0;
  logic saw_start;

  initial begin
    forever begin
      @(negedge clock);
      saw_start = tx_start;
      @(posedge clock);
      #2;
      if (!reset_n) begin
        tx_busy = 1'b0;
        tx_left = 0;
      end else if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) tx_busy = 1'b0;
      end else if (saw_start && !tx_ignore) begin
        tx_busy = 1'b1;
        tx_left = frame_len;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  int         cyc = 0;
  int         phase = 0;          // 0 free, 1 launched, 2 frame running, 3 finishing
  int         start_cyc = -100, done_cyc = -100, err_cyc = -100, free_at = -100;
  logic [1:0] m_baud = 2'b11;
  logic [1:0] m_pend_val = 2'b00;
  bit         m_pend = 1'b0;
  int         m_last = NUM_REQ - 1;
  logic [7:0] m_data = 8'h00;
  int         m_gid = 0;
  logic [7:0] exp_q[$];

  int         gnt_log[$];
  logic [7:0] byte_log[$];
  int         obs_start = -1, obs_err = -1, obs_done = -1, obs_fall = -1;
  logic       prev_busy = 1'b0;

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    logic [IDW-1:0] ii;
    for (int k = 1; k <= NUM_REQ; k++) begin
      ii = IDW'((last + k) % NUM_REQ);
      if (v[ii]) return int'(ii);
    end
    return -1;
  endfunction

  // Compare process: predicts every output each cycle from the scheduling rules
  always @(negedge clock) begin
    logic [NUM_REQ-1:0] e_ready;
    logic [1:0]         m_baud_n;
    logic [7:0]         byte_v;
    bit                 e_start, e_done, e_err, e_busy;
    int                 g;
    cyc++;
    if (!reset_n) begin
      phase = 0; m_baud = 2'b11; m_pend = 1'b0; m_last = NUM_REQ - 1;
      m_data = 8'h00; m_gid = 0; exp_q.delete();
      start_cyc = -100; done_cyc = -100; err_cyc = -100; free_at = -100;
      prev_busy = 1'b0;
    end else begin
      if (phase == 3 && cyc == free_at) phase = 0;
      e_start = (phase == 1 && cyc == start_cyc);
      e_done  = (cyc == done_cyc);
      e_err   = (cyc == err_cyc);
      e_busy  = (phase != 0);
      e_ready = '0;
      g = -1;
      if (phase == 0 && !m_pend && !cfg_update && (|req_valid)) begin
        g = rr_pick(req_valid, m_last);
        e_ready = NUM_REQ'(1) << g;
      end
      check("req_ready", req_ready, e_ready);
      check("tx_start", tx_start, e_start);
      check("frame_done", frame_done, e_done);
      check("err_timeout", err_timeout, e_err);
      check("sched_busy", sched_busy, e_busy);
      check("baud_rate", baud_rate, m_baud);
      check("tx_data_hold", tx_data, m_data);
      check("grant_id_hold", grant_id, m_gid);
      if (e_start && exp_q.size() > 0) check("tx_data_launch", tx_data, exp_q.pop_front());

      if (tx_start) begin
        obs_start = cyc;
        gnt_log.push_back(int'(grant_id));
        byte_log.push_back(tx_data);
      end
      if (err_timeout) obs_err = cyc;
      if (frame_done)  obs_done = cyc;
      if (prev_busy && !tx_busy) obs_fall = cyc;
      prev_busy = tx_busy;

      m_baud_n = m_baud;
      if (phase == 0) begin
        if (m_pend || cfg_update) begin
          m_baud_n = cfg_update ? cfg_baud : m_pend_val;
          m_pend = 1'b0;
        end else if (g >= 0) begin
          byte_v = 8'(req_data >> (8 * g));
          exp_q.push_back(byte_v);
          m_last = g; m_data = byte_v; m_gid = g;
          phase = 1; start_cyc = cyc + 1;
        end
      end else begin
        if (cfg_update) begin
          m_pend = 1'b1;
          m_pend_val = cfg_baud;
        end
        if (phase == 1 && cyc > start_cyc) begin
          if (tx_busy) phase = 2;
          else if (cyc == start_cyc + START_TIMEOUT - 1) begin
            err_cyc = cyc + 1; free_at = cyc + 1; phase = 3;
          end
        end else if (phase == 2) begin
          if (!tx_busy) begin
            done_cyc = cyc + 1; free_at = cyc + 1; phase = 3;
          end
        end
      end
      m_baud = m_baud_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    @(posedge clock);
    #1;
    reset_n = 1'b0; req_valid = '0; cfg_update = 1'b0; tx_ignore = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clock);
    while (req_ready == '0 && n < 100) begin @(negedge clock); n++; end
    check(name, {31'd0, (req_ready != '0)}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clock);
    while (!frame_done && n < 300) begin @(negedge clock); n++; end
    check(name, frame_done, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (sched_busy && n < 300) begin @(negedge clock); n++; end
    check("idle_reached", sched_busy, 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_baud", baud_rate, 2'b11);
    check("rst_sched_busy", sched_busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_ready", req_ready, 0);

    // baud change in IDLE lands next cycle
    @(posedge clock); #1 cfg_update = 1'b1; cfg_baud = 2'b10;
    @(posedge clock); #1 cfg_update = 1'b0;
    @(negedge clock);
    check("cfg_idle_baud", baud_rate, 2'b10);

    // single byte from requester 2, 40-cycle frame
    @(posedge clock); #1;
    frame_len = 40;
    req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    req_valid = 4'b0100;
    wait_ready("t2_ready_seen");
    check("t2_ready", req_ready, 4'b0100);
    @(posedge clock); #1 req_valid = '0;
    @(negedge clock);
    check("t2_start", tx_start, 1);
    check("t2_launch_data", tx_data, 8'hA5);
    wait_done("t2_done_seen");
    check("t2_data", tx_data, 8'hA5);
    check("t2_gid", grant_id, 2);
    #1 check("t2_done_lag", obs_done - obs_fall, 1);

    // all four requesters continuously valid
    reset_dut();
    frame_len = 2;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    gnt_log.delete(); byte_log.delete();
    n = 0;
    while (gnt_log.size() < 5 && n < 300) begin @(negedge clock); n++; end
    check("t3_five_grants", {31'd0, (gnt_log.size() >= 5)}, 32'd1);
    @(posedge clock); #1 req_valid = '0;
    if (gnt_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("t3_order", gnt_log[i], exp_order[i]);
        check("t3_byte", byte_log[i], 8'h10 + 8'(exp_order[i]));
      end
    end
    wait_idle();

    // baud updates during a frame apply only after it, before the next grant
    reset_dut();
    frame_len = 30;
    req_data = {8'h00, 8'h00, 8'h5C, 8'h77};
    req_valid = 4'b0010;
    wait_ready("t4_ready_seen");
    @(posedge clock); #1 req_valid = 4'b0001;
    n = 0;
    @(negedge clock);
    while (!tx_busy && n < 50) begin @(negedge clock); n++; end
    repeat (5) @(posedge clock);
    #1 cfg_update = 1'b1; cfg_baud = 2'b00;
    @(posedge clock); #1 cfg_baud = 2'b01;
    @(posedge clock); #1 cfg_update = 1'b0;
    @(negedge clock);
    check("t4_hold_mid_frame", baud_rate, 2'b11);
    wait_done("t4_done_seen");
    check("t4_baud_at_done", baud_rate, 2'b11);
    check("t4_no_grant_at_done", req_ready, 4'b0000);
    @(negedge clock);
    check("t4_baud_applied", baud_rate, 2'b01);
    check("t4_grant_after", req_ready, 4'b0001);
    @(posedge clock); #1 req_valid = '0;
    wait_idle();

    // transmitter ignores the launch: timeout, then next requester served
    frame_len = 3;
    tx_ignore = 1'b1;
    req_data = {8'h33, 8'h22, 8'h00, 8'h00};
    req_valid = 4'b1100;
    n = 0;
    @(negedge clock);
    while (!err_timeout && n < 100) begin @(negedge clock); n++; end
    check("t5_err_seen", err_timeout, 1);
    check("t5_err_idle", sched_busy, 0);
    #1;
    check("t5_err_delay", obs_err - obs_start, 16);
    check("t5_dropped_gid", gnt_log[gnt_log.size()-1], 2);
    @(posedge clock); #1 tx_ignore = 1'b0;
    n = 0;
    @(negedge clock);
    while (!tx_start && n < 50) begin @(negedge clock); n++; end
    check("t5_next_start", tx_start, 1);
    check("t5_next_gid", grant_id, 3);
    check("t5_next_data", tx_data, 8'h33);
    @(posedge clock); #1 req_valid = '0;
    wait_idle();

    // asynchronous reset in the middle of a frame
    frame_len = 40;
    req_data = {8'h00, 8'h00, 8'h66, 8'h00};
    req_valid = 4'b0010;
    wait_ready("t6_ready_seen");
    @(posedge clock); #1 req_valid = '0;
    repeat (8) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("t6_baud", baud_rate, 2'b11);
    check("t6_sched_busy", sched_busy, 0);
    check("t6_state", state_dbg, 0);
    check("t6_tx_data", tx_data, 0);
    check("t6_grant_id", grant_id, 0);
    check("t6_tx_start", tx_start, 0);
    check("t6_done", frame_done, 0);
    check("t6_err", err_timeout, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    frame_len = 2;
    req_valid = 4'b1111;
    wait_ready("t6_ready_after");
    check("t6_first_grant", req_ready, 4'b0001);
    @(posedge clock); #1 req_valid = '0;
    wait_idle();

    // random traffic, config pulses, short frames and occasional dead transmitter
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock); #1;
      req_valid  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      req_data   = $urandom();
      cfg_update = ($urandom_range(0, 9) == 0);
      cfg_baud   = 2'($urandom_range(0, 3));
      frame_len  = $urandom_range(1, 8);
      tx_ignore  = ($urandom_range(0, 15) == 0);
    end
    @(posedge clock); #1;
    req_valid = '0; cfg_update = 1'b0; tx_ignore = 1'b0;
    wait_idle();
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
